// File: rtl/serial_alu.sv
// Multi-cycle ALU: single-cycle logic/arithmetic ops, shifts by one bit per cycle.
// Results stay in a register until the consumer takes them.
module serial_alu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic [1:0]      dbg_state
);

  localparam int SHW = $clog2(XLEN);
  localparam logic [SHW-1:0] CNT_ONE = {{(SHW-1){1'b0}}, 1'b1};

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_SLTU = 4'b0110;
  localparam logic [3:0] OP_SLL  = 4'b0111;
  localparam logic [3:0] OP_SRL  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [SHW-1:0]  cnt_q, cnt_d;
  logic [3:0]      op_q, op_d;
  logic [XLEN-1:0] alu_res;
  logic [SHW-1:0]  shamt;
  logic            is_shift;

  // Handshake: a request transfers on a rising edge where in_valid && in_ready;
  // a result transfers on a rising edge where out_valid && out_ready.
  // Neither ready depends combinationally on the opposite valid.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = acc_q;
  assign zero      = (acc_q == '0);
  assign dbg_state = state_q;

  assign shamt    = src_b[SHW-1:0];
  assign is_shift = (alu_ctrl == OP_SLL) || (alu_ctrl == OP_SRL) || (alu_ctrl == OP_SRA);

  always_comb begin
    alu_res = '0;
    case (alu_ctrl)
      OP_ADD:  alu_res = src_a + src_b;
      OP_SUB:  alu_res = src_a - src_b;
      OP_AND:  alu_res = src_a & src_b;
      OP_OR:   alu_res = src_a | src_b;
      OP_XOR:  alu_res = src_a ^ src_b;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (src_a < src_b)};
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d = alu_ctrl;
          if (is_shift) begin
            acc_d   = src_a;
            cnt_d   = shamt;
            state_d = (shamt == '0) ? DONE : SHIFT;
          end else begin
            acc_d   = alu_res;
            cnt_d   = '0;
            state_d = DONE;
          end
        end
      end
      SHIFT: begin
        case (op_q)
          OP_SLL:  acc_d = {acc_q[XLEN-2:0], 1'b0};
          OP_SRL:  acc_d = {1'b0, acc_q[XLEN-1:1]};
          default: acc_d = {acc_q[XLEN-1], acc_q[XLEN-1:1]};
        endcase
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

endmodule

// File: tb/tb_serial_alu.sv
// Bench for serial_alu: vector table through a result/latency scoreboard,
// then backpressure, reset-in-flight and reset-with-request sequences.
module tb_serial_alu;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_ctrl;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic [1:0]  dbg_state;

  serial_alu #(.XLEN(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctrl  (alu_ctrl),
    .src_a     (src_a),
    .src_b     (src_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  localparam int NVEC = 27;
  vec_t vecs [NVEC];

  logic [31:0] exp_q [$];
  int          lat_q [$];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6: return (a < b) ? 32'd1 : 32'd0;
      4'd7: return a << b[4:0];
      4'd8: return a >> b[4:0];
      4'd9: return $signed(a) >>> b[4:0];
      default: return 32'd0;
    endcase
  endfunction

  // Called at a falling edge; returns at the falling edge after the accept.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp);
    int w;
    w = 0;
    in_valid = 1'b1;
    alu_ctrl = op;
    src_a    = a;
    src_b    = b;
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("issue_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    exp_q.push_back(exp);
    lat_q.push_back((op == 4'd7 || op == 4'd8 || op == 4'd9) ? 1 + int'(b[4:0]) : 1);
    @(negedge clk);
    in_valid = 1'b0;
    alu_ctrl = 4'($urandom_range(0, 15));
    src_a    = $urandom;
    src_b    = $urandom;
  endtask

  task automatic wait_result(input string name);
    int          lat;
    int          el;
    logic [31:0] e;
    lat = 1;
    while (!out_valid && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    chk({name, "_out_valid"}, {31'd0, out_valid}, 32'd1);
    chk({name, "_in_ready_low"}, {31'd0, in_ready}, 32'd0);
    e  = exp_q.pop_front();
    el = lat_q.pop_front();
    chk({name, "_latency"}, lat, el);
    chk({name, "_result"}, result, e);
    chk({name, "_zero"}, {31'd0, zero}, {31'd0, (e == 32'd0)});
  endtask

  task automatic expect_idle(input string name);
    @(negedge clk);
    chk({name, "_idle_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({name, "_idle_in_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [3:0]  rop;
    logic [31:0] ra, rb;

    vecs[0]  = '{4'd0, 32'd5,          32'd7,          32'd12};
    vecs[1]  = '{4'd1, 32'h1234,       32'h1234,       32'd0};
    vecs[2]  = '{4'd1, 32'd0,          32'd1,          32'hFFFF_FFFF};
    vecs[3]  = '{4'd5, 32'hFFFF_FFFF,  32'd1,          32'd1};
    vecs[4]  = '{4'd6, 32'hFFFF_FFFF,  32'd1,          32'd0};
    vecs[5]  = '{4'd9, 32'h8000_0000,  32'd4,          32'hF800_0000};
    vecs[6]  = '{4'd7, 32'd1,          32'h20,         32'd1};
    vecs[7]  = '{4'd8, 32'hFFFF_FFFF,  32'd31,         32'd1};
    vecs[8]  = '{4'd2, 32'h0000_F0F0,  32'h0000_FF00,  32'h0000_F000};
    vecs[9]  = '{4'd3, 32'h0000_F0F0,  32'h0000_FF00,  32'h0000_FFF0};
    vecs[10] = '{4'd4, 32'h0000_F0F0,  32'h0000_FF00,  32'h0000_0FF0};
    vecs[11] = '{4'd10, 32'd5,         32'd6,          32'd0};
    vecs[12] = '{4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'd0};
    vecs[13] = '{4'd7, 32'd1,          32'hFFFF_FFFF,  32'h8000_0000};
    vecs[14] = '{4'd9, 32'h7FFF_FFFF,  32'd1,          32'h3FFF_FFFF};
    vecs[15] = '{4'd0, 32'hFFFF_FFFF,  32'd1,          32'd0};
    vecs[16] = '{4'd8, 32'h8000_0000,  32'hFFFF_FFE1,  32'h4000_0000};
    for (int i = 17; i < NVEC; i++) begin
      rop = 4'($urandom_range(0, 11));
      ra  = $urandom;
      rb  = $urandom;
      vecs[i] = '{rop, ra, rb, model(rop, ra, rb)};
    end

    reset     = 1'b1;
    in_valid  = 1'b1;
    alu_ctrl  = 4'd0;
    src_a     = 32'd3;
    src_b     = 32'd4;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_zero", {31'd0, zero}, 32'd1);
    reset    = 1'b0;
    in_valid = 1'b0;
    expect_idle("post_reset");
    chk("post_reset_result", result, 32'd0);

    for (int i = 0; i < NVEC; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
      wait_result($sformatf("vec%0d", i));
      expect_idle($sformatf("vec%0d", i));
    end

    out_ready = 1'b0;
    issue(4'd0, 32'd3, 32'd4, 32'd7);
    wait_result("bp");
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1;
      alu_ctrl = 4'd1;
      src_a    = $urandom;
      src_b    = $urandom;
      chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_hold_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_hold_result", result, 32'd7);
      chk("bp_hold_zero", {31'd0, zero}, 32'd0);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    expect_idle("bp_release");
    expect_idle("bp_no_accept");
    chk("bp_result_kept", result, 32'd7);

    issue(4'd7, 32'd3, 32'd20, 32'd3 << 20);
    repeat (5) @(negedge clk);
    chk("rst_shift_state", {30'd0, dbg_state}, 32'd1);
    chk("rst_shift_busy", {31'd0, in_ready}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_shift_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_shift_result", result, 32'd0);
    chk("rst_shift_zero", {31'd0, zero}, 32'd1);
    chk("rst_shift_in_ready", {31'd0, in_ready}, 32'd1);
    exp_q.delete();
    lat_q.delete();
    for (int k = 0; k < 25; k++) begin
      chk("rst_shift_no_result", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
    end
    issue(4'd0, 32'd9, 32'd10, 32'd19);
    wait_result("after_rst");
    expect_idle("after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
